sdram_cmd_arbiter: RTL
======================

// Module: sdram_cmd_arbiter
// PURPOSE
//  N-channel arbiter in front of the SDRAM_16bit controller, clocked in the SDRAM clock domain.
//  Replaces the fixed video/cache if-chain in the top level with a parametrised block.
//  Channel 0 is the urgent channel (video refill) and has strict priority. Channels 1..N_CH-1
//  (cache, DMA, ...) share round-robin.
//  Tracks ownership of each burst and steers rd/wr data-valid strobes only to the owning channel.
// PARAMETERS
//  N_CH      4    number of requesters, 2..8
//  ADDR_W    23   SDRAM word-address width (sys_ADDR)
//  BL_SHORT  16   16-bit beats in a short read (cmd 2'b10, 32 bytes)
//  BL_LONG   128  16-bit beats in a long read/write (cmd 2'b11/2'b01, 256 bytes)
//  MAX_SKIP  4    skip limit used only when SDRAM_ARB_AGE_EN is defined
// PORTS
//  clk            in   1            SDRAM clock; single clock domain
//  rst            in   1            synchronous, active-high reset
//  req_i          in   N_CH         level request per channel; held until gnt_o for that channel
//  cmd_i          in   2*N_CH       per-channel command, slice [2k+1:2k]: 01 wr-long, 10 rd-short, 11 rd-long
//  addr_i         in   N_CH*ADDR_W  per-channel start address, slice k
//  gnt_o          out  N_CH         one-hot, 1-cycle pulse when the controller acks that channel's command
//  sys_cmd_o      out  2            to SDRAM sys_CMD; 00 = nop
//  sys_addr_o     out  ADDR_W       to SDRAM sys_ADDR
//  sys_cmd_ack_i  in   2            from SDRAM sys_cmd_ack
//  sys_rd_valid_i in   1            from SDRAM sys_rd_data_valid
//  sys_wr_valid_i in   1            from SDRAM sys_wr_data_valid
//  rd_valid_o     out  N_CH         sys_rd_valid_i steered to the owner
//  wr_valid_o     out  N_CH         sys_wr_valid_i steered to the owner
//  owner_o        out  CH_W         current owner; CH_W = $clog2(N_CH)
//  busy_o         out  1            1 in any state other than IDLE
//  err_o          out  1            sticky; set when ack code != latched cmd
// BEHAVIOUR
//  Reset values:
//   - all outputs 0; state IDLE; rr_ptr = 1.
//   - A reset mid-burst drops the burst. Strobes go low from the next edge.
//  Valid request: req_i[k] & cmd_k != 00. A request with cmd 00 is ignored.
//  IDLE:
//   - Winner is ch0 if valid. Otherwise the first valid channel at or after rr_ptr, wrapping and skipping 0.
//   - Latch winner, cmd and addr. Drive sys_cmd_o/sys_addr_o from the registers. Go to ISSUE.
//   - Latency from req to sys_cmd_o is 1 clk.
//  ISSUE:
//   - Hold sys_cmd_o/sys_addr_o until sys_cmd_ack_i != 00.
//   - On that cycle:
//     - sys_cmd_o <= 00; gnt_o[owner] pulses.
//     - beat counter <= BL_SHORT for cmd 10, else BL_LONG.
//     - If ack != latched cmd, set err_o.
//     - Go to BURST.
//   - Dropping req_i during ISSUE does not withdraw the command.
//  BURST:
//   - rd_valid_o[owner] = sys_rd_valid_i, but only for read cmds.
//   - wr_valid_o[owner] = sys_wr_valid_i, but only for cmd 01.
//   - Steering is combinational, zero latency. Non-owner and wrong-direction strobes are 0.
//   - Each steered strobe decrements the counter. On the strobe that takes it 1->0, go to IDLE.
//   - Strobes while IDLE or ISSUE are discarded. They do not set err_o.
//  Round robin: when a burst owned by ch k>=1 finishes, rr_ptr <= k+1, wrapping N_CH-1 -> 1.
//   A ch0 burst leaves rr_ptr unchanged.
//  Back-to-back: the next arbitration occurs in the IDLE cycle after BURST.
//   A new command issues 1 clk after the last strobe.
//  owner_o holds its last value through IDLE.
// CONFIGURATION
//  SDRAM_ARB_AGE_EN defined:
//   - Each channel k>=1 has a skip counter (width $clog2(MAX_SKIP+1)).
//   - The counter increments when ch0 wins while ch k is validly requesting.
//   - When the counter reaches MAX_SKIP, ch k beats ch0 at the next arbitration.
//     Among aged channels the RR order applies.
//   - The counter clears when ch k is granted, and on rst.
//  SDRAM_ARB_AGE_EN undefined: strict ch0 priority; no skip counters.
// TESTING
//  1. Only ch1 requests cmd 11, addr 0x000040; ack 11 after 3 clks; 128 rd strobes.
//     -> sys_cmd_o=11 1 clk after req; gnt_o=0010 on the ack cycle.
//     -> rd_valid_o[1] toggles 128x; busy_o falls after the 128th strobe.
//  2. ch0 (cmd 10) and ch2 (cmd 01) request together.
//     -> ch0 granted first, 16 rd beats.
//     -> ch2 issued 1 clk after ch0's last strobe; 128 wr beats appear on wr_valid_o[2] only.
//  3. ch1, ch2, ch3 all request continuously.
//     -> grant order 1,2,3,1,2 (one gnt pulse each).
//  4. Reset asserted at beat 50 of a long read, with ack=11 given for cmd 01.
//     -> err_o=1 before the reset; after reset, all outputs 0 and err_o clears.
//     -> Strobes arriving after reset are not steered.
//  5. With SDRAM_ARB_AGE_EN, MAX_SKIP=4: ch0 requests continuously, ch1 requests.
//     -> ch1 granted after exactly 4 ch0 bursts.
//     -> Without the macro, ch1 is never granted while ch0 keeps requesting.

Source files
------------

// File: rtl/sdram_cmd_arbiter.sv
// N-channel command arbiter in front of the 16-bit SDRAM controller: ch0 strict priority, ch1..N_CH-1 round-robin.
// Optional starvation guard for ch1..N_CH-1 is compiled in with `define SDRAM_ARB_AGE_EN.
module sdram_cmd_arbiter #(
    parameter int N_CH     = 4,
    parameter int ADDR_W   = 23,
    parameter int BL_SHORT = 16,
    parameter int BL_LONG  = 128,
    parameter int MAX_SKIP = 4,
    localparam int CH_W    = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          req_i,
    input  logic [2*N_CH-1:0]        cmd_i,
    input  logic [N_CH*ADDR_W-1:0]   addr_i,
    output logic [N_CH-1:0]          gnt_o,
    output logic [1:0]               sys_cmd_o,
    output logic [ADDR_W-1:0]        sys_addr_o,
    input  logic [1:0]               sys_cmd_ack_i,
    input  logic                     sys_rd_valid_i,
    input  logic                     sys_wr_valid_i,
    output logic [N_CH-1:0]          rd_valid_o,
    output logic [N_CH-1:0]          wr_valid_o,
    output logic [CH_W-1:0]          owner_o,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int CNT_W = $clog2(BL_LONG + 1);
    localparam logic [N_CH-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     owner_q, owner_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [1:0]          cmd_q, cmd_d;
    logic [1:0]          sys_cmd_q, sys_cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [1:0]          cmd_a  [N_CH];
    logic [ADDR_W-1:0]   addr_a [N_CH];
    logic [N_CH-1:0]     vld, aged, rr_mask, owner_oh;
    logic [CH_W:0]       aged_res, rr_res;
    logic                win_vld, ack_hit, in_burst, is_rd, is_wr, strobe;
    logic [CH_W-1:0]     win_idx;

    // Returns {hit, index} of the first set bit at or after ptr, cycling over 1..N_CH-1.
    function automatic logic [CH_W:0] rr_pick(input logic [N_CH-1:0] mask,
                                              input logic [CH_W-1:0] ptr);
        logic [CH_W-1:0] cand;
        logic [CH_W-1:0] sel;
        logic            hit;
        cand = ptr;
        sel  = '0;
        hit  = 1'b0;
        for (int i = 0; i < N_CH - 1; i++) begin
            if (!hit && mask[cand]) begin
                hit = 1'b1;
                sel = cand;
            end
            cand = (cand == CH_W'(N_CH - 1)) ? CH_W'(1) : cand + CH_W'(1);
        end
        return {hit, sel};
    endfunction

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign cmd_a[k]  = cmd_i[2*k +: 2];
        assign addr_a[k] = addr_i[k*ADDR_W +: ADDR_W];
        assign vld[k]    = req_i[k] & (cmd_i[2*k +: 2] != 2'b00);
    end

`ifdef SDRAM_ARB_AGE_EN
    localparam int SK_W = $clog2(MAX_SKIP + 1);
    logic [SK_W-1:0] skip_q [N_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) skip_q[k] <= '0;
        end else begin
            for (int k = 1; k < N_CH; k++) begin
                if (ack_hit && owner_q == CH_W'(k)) begin
                    skip_q[k] <= '0;
                end else if (state_q == IDLE && win_vld && win_idx == '0 && vld[k]
                             && skip_q[k] != SK_W'(MAX_SKIP)) begin
                    skip_q[k] <= skip_q[k] + SK_W'(1);
                end
            end
        end
    end

    always_comb begin
        aged = '0;
        for (int k = 1; k < N_CH; k++) aged[k] = (skip_q[k] == SK_W'(MAX_SKIP));
    end
`else
    assign aged = '0;
`endif

    // Aged low-priority channels beat ch0; otherwise ch0 first, then round-robin.
    assign rr_mask  = {vld[N_CH-1:1], 1'b0};
    assign aged_res = rr_pick(rr_mask & aged, rr_ptr_q);
    assign rr_res   = rr_pick(rr_mask, rr_ptr_q);
    assign win_vld  = |vld;

    always_comb begin
        if (aged_res[CH_W])  win_idx = aged_res[CH_W-1:0];
        else if (vld[0])     win_idx = '0;
        else                 win_idx = rr_res[CH_W-1:0];
    end

    assign owner_oh = ONE << owner_q;
    assign ack_hit  = (state_q == ISSUE) && (sys_cmd_ack_i != 2'b00);
    assign in_burst = (state_q == BURST);
    assign is_rd    = cmd_q[1];
    assign is_wr    = (cmd_q == 2'b01);
    assign strobe   = in_burst && ((is_rd && sys_rd_valid_i) || (is_wr && sys_wr_valid_i));

    assign gnt_o      = ack_hit ? owner_oh : '0;
    assign rd_valid_o = (in_burst && is_rd && sys_rd_valid_i) ? owner_oh : '0;
    assign wr_valid_o = (in_burst && is_wr && sys_wr_valid_i) ? owner_oh : '0;
    assign sys_cmd_o  = sys_cmd_q;
    assign sys_addr_o = addr_q;
    assign owner_o    = owner_q;
    assign busy_o     = (state_q != IDLE);
    assign err_o      = err_q;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        cmd_d     = cmd_q;
        sys_cmd_d = sys_cmd_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    owner_d   = win_idx;
                    cmd_d     = cmd_a[win_idx];
                    sys_cmd_d = cmd_a[win_idx];
                    addr_d    = addr_a[win_idx];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (ack_hit) begin
                    sys_cmd_d = 2'b00;
                    cnt_d     = (cmd_q == 2'b10) ? CNT_W'(BL_SHORT) : CNT_W'(BL_LONG);
                    if (sys_cmd_ack_i != cmd_q) err_d = 1'b1;
                    state_d   = BURST;
                end
            end
            BURST: begin
                if (strobe) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        if (owner_q != '0)
                            rr_ptr_d = (owner_q == CH_W'(N_CH - 1)) ? CH_W'(1) : owner_q + CH_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= CH_W'(1);
            cmd_q     <= 2'b00;
            sys_cmd_q <= 2'b00;
            addr_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            cmd_q     <= cmd_d;
            sys_cmd_q <= sys_cmd_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

endmodule
